// File: rtl/press_event_decoder_pkg.sv
// Shared state encoding and default timing constants for the press event decoder.
package press_event_decoder_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_LOCKOUT = 2'd2;

  // Defaults assume a 100 MHz clock.
  localparam int unsigned WINDOW_250MS  = 32'd25000000;
  localparam int unsigned LOCKOUT_100MS = 32'd10000000;

endpackage

// File: rtl/press_event_decoder.sv
// Classifies debounced press pulses into single and double presses, with a
// lockout after each double press to swallow stray re-triggers.
module press_event_decoder
  import press_event_decoder_pkg::*;
#(
  parameter int unsigned WINDOW  = WINDOW_250MS,
  parameter int unsigned LOCKOUT = LOCKOUT_100MS,
  parameter int unsigned CNT_W   = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic press,
  output logic single_press,
  output logic double_press,
  output logic busy
);

  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  assign busy = (state != ST_IDLE);

  // One counter serves both timed states; it is cleared on every state entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      single_press <= 1'b0;
      double_press <= 1'b0;
    end else begin
      single_press <= 1'b0;
      double_press <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (press) begin
            state <= ST_ARMED;
            cnt   <= '0;
          end
        end
        ST_ARMED: begin
          // A press on the timeout cycle still counts as the second press.
          if (press) begin
            double_press <= 1'b1;
            state        <= ST_LOCKOUT;
            cnt          <= '0;
          end else if (cnt == WIN_LAST) begin
            single_press <= 1'b1;
            state        <= ST_IDLE;
            cnt          <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_LOCKOUT: begin
          if (cnt == LOCK_LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_press_event_decoder.sv
// Randomized and directed bench for press_event_decoder against an
// interval-based behavioural model of the press classification rules.
module tb_press_event_decoder;

  localparam int WINDOW  = 8;
  localparam int LOCKOUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic press = 1'b0;
  logic single_press, double_press, busy;

  int checks = 0;
  int failures = 0;
  int tcount = 0;

  press_event_decoder #(
    .WINDOW (WINDOW),
    .LOCKOUT(LOCKOUT),
    .CNT_W  (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .press       (press),
    .single_press(single_press),
    .double_press(double_press),
    .busy        (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) tcount <= tcount + 1;

  // ---------------- behavioural model ----------------
  // Armed and lockout periods are kept as absolute cycle intervals.
  int arm_lo = -1, arm_hi = -2, lock_lo = -1, lock_hi = -2;
  logic exp_s = 1'b0, exp_d = 1'b0, exp_b = 1'b0;
  int sq[$];
  int dq[$];
  int bq[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      arm_lo = -1; arm_hi = -2; lock_lo = -1; lock_hi = -2;
      exp_s = 1'b0; exp_d = 1'b0; exp_b = 1'b0;
    end else begin
      int t;
      logic ns, nd;
      t  = tcount;
      ns = 1'b0;
      nd = 1'b0;
      if (t >= arm_lo && t <= arm_hi) begin
        if (press) begin
          nd      = 1'b1;
          arm_hi  = t;
          lock_lo = t + 1;
          lock_hi = t + LOCKOUT;
        end else if (t == arm_hi) begin
          ns = 1'b1;
        end
      end else if (!(t >= lock_lo && t <= lock_hi)) begin
        if (press) begin
          arm_lo = t + 1;
          arm_hi = t + WINDOW;
        end
      end
      exp_s = ns;
      exp_d = nd;
      exp_b = ((t + 1 >= arm_lo) && (t + 1 <= arm_hi)) ||
              ((t + 1 >= lock_lo) && (t + 1 <= lock_hi));
      if (ns) sq.push_back(t + 1);
      if (nd) dq.push_back(t + 1);
      if (exp_b) bq.push_back(t + 1);
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    checks++;
    if ({single_press, double_press, busy} !== {exp_s, exp_d, exp_b}) begin
      failures++;
      $display("FAIL outputs cycle=%0d actual s/d/b=%b%b%b required=%b%b%b",
               tcount, single_press, double_press, busy, exp_s, exp_d, exp_b);
    end
  end

  // ---------------- helpers ----------------
  function automatic int count_in(input int q[$], input int lo, input int hi);
    int n = 0;
    foreach (q[i]) if (q[i] >= lo && q[i] < hi) n++;
    return n;
  endfunction

  function automatic int first_in(input int q[$], input int lo, input int hi);
    foreach (q[i]) if (q[i] >= lo && q[i] < hi) return q[i] - lo;
    return -1;
  endfunction

  task automatic pin(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  // Relative cycle 0 is the cycle in which the scenario starts driving.
  task automatic scn(input string name, input int p0, input int p1, input int p2,
                     input int rst_at, input int span,
                     input int n_s, input int f_s, input int n_d, input int f_d,
                     input int n_b);
    int base;
    @(negedge clk);
    base = tcount;
    for (int r = 0; r < span; r++) begin
      if (r > 0) @(negedge clk);
      press = (r == p0) || (r == p1) || (r == p2);
      if (r == rst_at) begin
        press = 1'b0;
        #1 rst = 1'b1;
        #3 rst = 1'b0;
      end
    end
    @(negedge clk);
    press = 1'b0;
    pin({name, "_n_single"}, count_in(sq, base, base + span), n_s);
    pin({name, "_first_single"}, first_in(sq, base, base + span), f_s);
    pin({name, "_n_double"}, count_in(dq, base, base + span), n_d);
    pin({name, "_first_double"}, first_in(dq, base, base + span), f_d);
    pin({name, "_busy_cycles"}, count_in(bq, base, base + span), n_b);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    scn("idle",       -1, -1, -1, -1, 20, 0, -1, 0, -1, 0);
    scn("single",      0, -1, -1, -1, 20, 1,  9, 0, -1, 8);
    scn("double",      0,  3, -1, -1, 20, 0, -1, 1,  4, 7);
    scn("tie",         0,  8, -1, -1, 20, 0, -1, 1,  9, 12);
    scn("after_tie",   0,  9, -1, -1, 25, 2,  9, 0, -1, 16);
    scn("lock_drop",   0,  2,  6, -1, 20, 0, -1, 1,  3, 6);
    scn("lock_resume", 0,  2,  7, -1, 25, 1, 16, 1,  3, 14);
    scn("reset_mid",   0, 10, -1,  4, 30, 1, 19, 0, -1, 12);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      press = ($urandom_range(0, 99) < 20);
      if ($urandom_range(0, 499) == 0) begin
        press = 1'b0;
        #1 rst = 1'b1;
        #3 rst = 1'b0;
      end
    end
    @(negedge clk);
    press = 1'b0;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
